// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: Fibonacci LFSR random source with seed load, step enable and
// a bounded-range rejection-sampling draw engine with a fallback after MAX_TRIES.
module lfsr_rand_gen #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] TAPS      = 12'h053,
    parameter logic [WIDTH-1:0] SEED      = 12'h001,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state_out,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] value
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    typedef enum logic {IDLE, SAMPLE} st_t;
    st_t st, st_d;
    logic [WIDTH-1:0] lfsr_d, stepped, cand, limit_q, limit_d, mask_q, mask_d, value_d;
    logic [TW-1:0] tries, tries_d;
    logic valid_d, accept;

    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = x;
        for (int i = 1; i < WIDTH; i = i * 2) r = r | (r >> i);
        return r;
    endfunction

    // all-zero state would lock up; escape to all-ones instead
    assign stepped = (state_out == '0) ? '1 : {^(state_out & TAPS), state_out[WIDTH-1:1]};
    assign cand    = state_out & mask_q;
    assign accept  = (limit_q == '0) || (cand < limit_q);
    assign busy    = (st == SAMPLE);
    assign lfsr_d  = load ? load_val : (busy || en) ? stepped : state_out;

    always_comb begin
        st_d    = st;
        limit_d = limit_q;
        mask_d  = mask_q;
        tries_d = tries;
        value_d = value;
        valid_d = 1'b0;
        if (st == IDLE) begin
            if (req) begin
                limit_d = limit;
                mask_d  = (limit == '0) ? '1 : smear(limit - 1'b1);
                tries_d = '0;
                st_d    = SAMPLE;
            end
        end else if (accept || tries == TW'(MAX_TRIES - 1)) begin
            value_d = accept ? cand : cand - limit_q;
            valid_d = 1'b1;
            st_d    = IDLE;
        end else begin
            tries_d = tries + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            state_out <= SEED;
            limit_q   <= '0;
            mask_q    <= '0;
            tries     <= '0;
            valid     <= 1'b0;
            value     <= '0;
        end else begin
            st        <= st_d;
            state_out <= lfsr_d;
            limit_q   <= limit_d;
            mask_q    <= mask_d;
            tries     <= tries_d;
            valid     <= valid_d;
            value     <= value_d;
        end
    end
endmodule

// File: doc/lfsr_rand_gen.md
# lfsr_rand_gen

Parametrised Fibonacci LFSR random source with seed load, step enable and a bounded-range draw engine. A draw returns a uniform value in [0, limit) using rejection sampling with a guaranteed upper bound on latency. It serves game and test logic that needs either a free-running random word or an on-demand bounded random number.

## Interface
- WIDTH, 12: LFSR and data width; legal range 4..32.
- TAPS, 12'h053: feedback mask. Bit i set means state bit i enters the XOR feedback.
- SEED, 12'h001: state after reset. Zero is legal and is handled by the lock-up escape.
- MAX_TRIES, 8: maximum sampling cycles per draw before the fallback path is taken; ≥1.

Ports. Reset is rst, synchronous, active-high; clock is clk.
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- en, in, 1: step the LFSR once this cycle while the FSM is in IDLE.
- load, in, 1: replace the LFSR state with load_val; highest priority.
- load_val, in, WIDTH: load value.
- state_out, out, WIDTH: raw LFSR register.
- req, in, 1: draw request; sampled only in IDLE.
- limit, in, WIDTH: exclusive upper bound, captured with req. Zero means full range.
- busy, out, 1: high while the FSM is in SAMPLE.
- valid, out, 1: one-cycle pulse; value is valid.
- value, out, WIDTH: draw result; held until the next valid.

## Operation
- **Step function.** fb = ^(state & TAPS); next = {fb, state[WIDTH-1:1]}.
- **Lock-up escape.** When state == 0, a step produces all-ones instead of applying the XOR feedback. All-ones is an ordinary state.
- **LFSR update priority, per cycle:**
  1. rst → SEED
  2. load → load_val
  3. FSM in SAMPLE → step (en is ignored)
  4. en → step
  5. otherwise hold
- **IDLE state.**
  - If req is high, capture limit_q = limit and mask_q = smear(limit−1), the smallest 2^k−1 that is ≥ limit−1.
  - If limit == 0, mask_q = all-ones.
  - Clear tries and go to SAMPLE. The LFSR does not step on the capture cycle unless en is high.
- **SAMPLE state.**
  - Compute cand = state & mask_q.
  - Accept when limit_q == 0 or cand < limit_q. On accept: value ← cand, valid ← 1, go to IDLE.
  - Otherwise, if tries == MAX_TRIES−1, take the fallback: value ← cand − limit_q (always < limit_q, since cand < 2·limit_q), valid ← 1, go to IDLE.
  - Otherwise, tries++ and remain in SAMPLE.
  - The LFSR steps on every SAMPLE cycle, so each draw consumes ≥1 step.
- **Special limits.** limit == 1 gives mask 0, so the draw always returns 0 on its first SAMPLE cycle.
- **req while busy** is ignored; it is neither queued nor latched.
- **load during SAMPLE.** Load wins over the step. The next SAMPLE cycle uses the loaded state; the draw continues with tries unchanged.
- **rst mid-draw.**
  - FSM returns to IDLE; busy, valid and value go to 0; state goes to SEED.
  - The draw in progress is abandoned and no valid is produced.
- **Reset values:** state_out = SEED, busy = 0, valid = 0, value = 0, FSM = IDLE, tries = 0.

## Timing
- **Draw latency.** req is captured at edge N. busy is high from N+1. On first-try accept, valid = 1 and busy = 0 in the cycle after edge N+2. The latency from req to valid is 2 + (number of rejections) cycles, bounded by MAX_TRIES+1.
- **Back-to-back draws.** req may be high in the same cycle valid is high, because the FSM is in IDLE then. The minimum draw period is 2 cycles.
- **Register timing.** state_out, value and valid are registers; no combinational path runs from input to output.
- **Arithmetic.** All arithmetic is WIDTH bits and unsigned; the compare is an unsigned <. limit−1 is evaluated only for limit ≥ 1.

## Test plan
- **LFSR step sequence.** Defaults; hold rst, then run en = 1 for 3 cycles → state_out goes 001 → 800 → 400 → 200.
- **Lock-up escape.** Load 0x000, then en = 1 for 2 cycles → state_out goes 000 → FFF → 7FF.
- **First-try draws.** After reset, en = 0, req = 1 with limit = 5 for one cycle → valid pulses 2 cycles later with value = 1 and state_out = 800. An immediate second req with limit = 5 → value = 0, state_out = 400.
- **Rejection path.** Load 0x006, then req with limit = 5 → the first SAMPLE cycle rejects cand = 6, state becomes 0x803, cand = 3 accepts. valid arrives 3 cycles after req with value = 3, and busy is high for 2 cycles.
- **Fallback path.** With MAX_TRIES = 1, load 0x006, then req with limit = 5 → value = 1 arrives 2 cycles after req. Also drive req while busy and check that it is ignored: exactly one valid pulse.
- **Reset and load interactions.** Assert rst during SAMPLE → no valid; busy = 0, value = 0 and state_out = SEED next cycle. Assert load and en together → load_val wins.
